l1_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one L1 AXI read port (`m_axi_l1_V_AR*`/`R*`) among `N_REQ` application cores, such as the DES gate-evaluation cores. Each core keeps its own single-ID read master interface. The arbiter serializes AR requests, remembers grant order in an in-order tag FIFO, and steers returning R beats back to the owning core. Write channels (AW/W/B) and the undo log are outside this block.

---
 rtl/l1_rd_arbiter.sv | 139 +++++++++++++
 tb/tb_l1_rd_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/l1_rd_arbiter.sv
// Round-robin arbiter sharing one L1 AXI read port among N_REQ single-ID read masters.
// Define L1_ARB_PRIO0_EN to give requester 0 fixed priority over the round-robin group.
module l1_rd_arbiter #(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst,
    input  logic [N_REQ-1:0]                   s_arvalid,
    output logic [N_REQ-1:0]                   s_arready,
    input  logic [N_REQ*32-1:0]                s_araddr,
    input  logic [N_REQ*8-1:0]                 s_arlen,
    input  logic [N_REQ*3-1:0]                 s_arsize,
    output logic [N_REQ-1:0]                   s_rvalid,
    input  logic [N_REQ-1:0]                   s_rready,
    output logic [31:0]                        s_rdata,
    output logic                               s_rlast,
    output logic [1:0]                         s_rresp,
    output logic                               m_axi_l1_V_ARVALID,
    input  logic                               m_axi_l1_V_ARREADY,
    output logic [31:0]                        m_axi_l1_V_ARADDR,
    output logic [7:0]                         m_axi_l1_V_ARLEN,
    output logic [2:0]                         m_axi_l1_V_ARSIZE,
    input  logic                               m_axi_l1_V_RVALID,
    output logic                               m_axi_l1_V_RREADY,
    input  logic [31:0]                        m_axi_l1_V_RDATA,
    input  logic                               m_axi_l1_V_RLAST,
    input  logic [1:0]                         m_axi_l1_V_RRESP,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                               stray_beat
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic          slot_valid_q;
    logic [31:0]   slot_addr_q;
    logic [7:0]    slot_len_q;
    logic [2:0]    slot_size_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] tag_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          stray_q;

    logic          empty, full, pop, push, slot_free;
    logic [IW-1:0] head, win;
    logic [N_REQ-1:0] rr_req;
    logic          rr_found;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(MAX_OUTSTANDING));
    assign head      = tag_q[rd_ptr_q];
    assign m_axi_l1_V_RREADY = empty ? 1'b1 : s_rready[head];
    assign pop       = m_axi_l1_V_RVALID & m_axi_l1_V_RREADY & m_axi_l1_V_RLAST & ~empty;
    assign slot_free = ~slot_valid_q | (m_axi_l1_V_ARVALID & m_axi_l1_V_ARREADY);
    assign push      = slot_free & (~full | pop) & (|s_arvalid);

    // Requester 0 is removed from the rotation when it has fixed priority.
    always_comb begin
        rr_req = s_arvalid;
`ifdef L1_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
    end

    always_comb begin
        win      = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            if (!rr_found && rr_req[IW'((int'(rr_ptr_q) + k) % int'(N_REQ))]) begin
                win      = IW'((int'(rr_ptr_q) + k) % int'(N_REQ));
                rr_found = 1'b1;
            end
        end
`ifdef L1_ARB_PRIO0_EN
        if (s_arvalid[0]) win = '0;
`endif
    end

    always_comb begin
        s_arready = '0;
        if (push) s_arready[win] = 1'b1;
        s_rvalid = '0;
        if (m_axi_l1_V_RVALID && !empty) s_rvalid[head] = 1'b1;
    end

    assign s_rdata            = m_axi_l1_V_RDATA;
    assign s_rlast            = m_axi_l1_V_RLAST;
    assign s_rresp            = m_axi_l1_V_RRESP;
    assign m_axi_l1_V_ARVALID = slot_valid_q;
    assign m_axi_l1_V_ARADDR  = slot_addr_q;
    assign m_axi_l1_V_ARLEN   = slot_len_q;
    assign m_axi_l1_V_ARSIZE  = slot_size_q;
    assign outstanding        = count_q;
    assign stray_beat         = stray_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_len_q   <= '0;
            slot_size_q  <= '0;
            rr_ptr_q     <= IW'(N_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stray_q      <= 1'b0;
        end else begin
            if (push) begin
                slot_valid_q <= 1'b1;
                slot_addr_q  <= s_araddr[32*int'(win) +: 32];
                slot_len_q   <= s_arlen[8*int'(win) +: 8];
                slot_size_q  <= s_arsize[3*int'(win) +: 3];
                wr_ptr_q     <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
`ifdef L1_ARB_PRIO0_EN
                if (win != '0) rr_ptr_q <= win;
`else
                rr_ptr_q <= win;
`endif
            end else if (m_axi_l1_V_ARVALID && m_axi_l1_V_ARREADY) begin
                slot_valid_q <= 1'b0;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (m_axi_l1_V_RVALID && empty) stray_q <= 1'b1;
        end
    end

    // Tag storage needs no reset; occupancy decides which entries are live.
    always_ff @(posedge ap_clk) begin
        if (push) tag_q[wr_ptr_q] <= win;
    end

endmodule

// File: tb/tb_l1_rd_arbiter.sv
// Directed bench for l1_rd_arbiter: round-robin order, full FIFO, bursts, backpressure, reset.
module tb_l1_rd_arbiter;
    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic [3:0]   s_arvalid, s_arready, s_rvalid, s_rready;
    logic [127:0] s_araddr;
    logic [31:0]  s_arlen;
    logic [11:0]  s_arsize;
    logic [31:0]  s_rdata;
    logic         s_rlast;
    logic [1:0]   s_rresp;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [31:0]  araddr, rdata;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   rresp;
    logic [2:0]   outstanding;
    logic         stray_beat;
    int           checks = 0;
    int           errors = 0;

    l1_rd_arbiter #(.N_REQ(4), .MAX_OUTSTANDING(4)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rresp(s_rresp),
        .m_axi_l1_V_ARVALID(arvalid), .m_axi_l1_V_ARREADY(arready),
        .m_axi_l1_V_ARADDR(araddr), .m_axi_l1_V_ARLEN(arlen), .m_axi_l1_V_ARSIZE(arsize),
        .m_axi_l1_V_RVALID(rvalid), .m_axi_l1_V_RREADY(rready), .m_axi_l1_V_RDATA(rdata),
        .m_axi_l1_V_RLAST(rlast), .m_axi_l1_V_RRESP(rresp),
        .outstanding(outstanding), .stray_beat(stray_beat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
        s_araddr[32*i +: 32] = a;
        s_arlen[8*i +: 8]    = l;
        s_arsize[3*i +: 3]   = 3'd2;
    endtask

    initial begin
        ap_rst = 1'b1; s_arvalid = '0; s_rready = 4'hF; s_araddr = '0; s_arlen = '0;
        s_arsize = '0; arready = 1'b1; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = '0;
        #12;
        chk("rst_arready", 64'(s_arready), 64'h0);
        chk("rst_rvalid", 64'(s_rvalid), 64'h0);
        chk("rst_arvalid", 64'(arvalid), 64'h0);
        chk("rst_araddr", 64'({araddr, arlen, arsize}), 64'h0);
        chk("rst_rready", 64'(rready), 64'h1);
        chk("rst_outstanding", 64'(outstanding), 64'h0);
        chk("rst_stray", 64'(stray_beat), 64'h0);

        // Round-robin: all four request, grants 0,1,2,3.
        ap_rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'h100 * (i + 1), 8'd0);
        s_arvalid = 4'hF; #1;
        chk("rr_grant0", 64'(s_arready), 64'h1);
        tick(); s_arvalid = 4'hE; #1;
        chk("rr_addr0", 64'(araddr), 64'h100);
        chk("rr_arvalid", 64'(arvalid), 64'h1);
        chk("rr_grant1", 64'(s_arready), 64'h2);
        tick(); s_arvalid = 4'hC; #1;
        chk("rr_addr1", 64'(araddr), 64'h200);
        chk("rr_grant2", 64'(s_arready), 64'h4);
        tick(); s_arvalid = 4'h8; #1;
        chk("rr_addr2", 64'(araddr), 64'h300);
        chk("rr_grant3", 64'(s_arready), 64'h8);
        tick(); s_arvalid = 4'h0;
        chk("rr_addr3", 64'(araddr), 64'h400);
        chk("rr_outstanding4", 64'(outstanding), 64'h4);

        // Full FIFO: core 1 blocked until the first RLAST.
        set_req(1, 32'h500, 8'd0); s_arvalid = 4'h2; #1;
        chk("full_arready0", 64'(s_arready), 64'h0);
        tick();
        chk("full_arready1", 64'(s_arready), 64'h0);
        chk("full_arvalid_drop", 64'(arvalid), 64'h0);
        chk("full_outstanding", 64'(outstanding), 64'h4);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'hA0; rresp = 2'd1; #1;
        chk("ret_rvalid0", 64'(s_rvalid), 64'h1);
        chk("ret_rdata0", 64'({s_rdata, s_rresp, s_rlast}), 64'({32'hA0, 2'd1, 1'b1}));
        chk("full_grant_on_pop", 64'(s_arready), 64'h2);
        tick(); s_arvalid = 4'h0; rdata = 32'hB1; #1;
        chk("full_addr", 64'(araddr), 64'h500);
        chk("pushpop_outstanding", 64'(outstanding), 64'h4);
        chk("ret_rvalid1", 64'(s_rvalid), 64'h2);
        tick(); #1;
        chk("ret_rvalid2", 64'(s_rvalid), 64'h4);
        tick(); #1;
        chk("ret_rvalid3", 64'(s_rvalid), 64'h8);
        tick(); #1;
        chk("ret_rvalid_core1", 64'(s_rvalid), 64'h2);
        tick(); rvalid = 1'b0; rlast = 1'b0; rresp = '0;
        chk("drain_outstanding", 64'(outstanding), 64'h0);

        // Multi-beat burst on core 2 with s_rready[2] = 1,0,1,1,1.
        set_req(2, 32'h600, 8'd3); s_arvalid = 4'h4; #1;
        chk("burst_grant", 64'(s_arready), 64'h4);
        tick(); s_arvalid = 4'h0;
        chk("burst_arlen", 64'(arlen), 64'h3);
        chk("burst_outstanding", 64'(outstanding), 64'h1);
        rvalid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            s_rready = (b == 1) ? 4'h0 : 4'h4;
            rlast = (b == 4);
            #1;
            chk("burst_rready", 64'(rready), 64'((b == 1) ? 0 : 1));
            chk("burst_rvalid", 64'(s_rvalid), 64'h4);
            tick();
            if (b < 4) chk("burst_no_pop", 64'(outstanding), 64'h1);
        end
        rvalid = 1'b0; rlast = 1'b0; s_rready = 4'hF;
        chk("burst_popped", 64'(outstanding), 64'h0);

        // AR backpressure: slot holds while ARREADY is low.
        arready = 1'b0; set_req(3, 32'h700, 8'd0); s_arvalid = 4'hA; #1;
        chk("bp_grant3", 64'(s_arready), 64'h8);
        tick(); s_arvalid = 4'h2;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_grant", 64'(s_arready), 64'h0);
            chk("bp_hold", 64'({arvalid, araddr}), 64'({1'b1, 32'h700}));
            tick();
        end
        arready = 1'b1; #1;
        chk("bp_grant_on_ready", 64'(s_arready), 64'h2);
        tick(); s_arvalid = 4'h0;
        chk("bp_next_addr", 64'(araddr), 64'h500);
        chk("bp_outstanding", 64'(outstanding), 64'h2);
        tick();

        // Asynchronous reset with two bursts outstanding, then a stray beat.
        #2; ap_rst = 1'b1; #1;
        chk("mid_rst_outstanding", 64'(outstanding), 64'h0);
        chk("mid_rst_arvalid", 64'(arvalid), 64'h0);
        ap_rst = 1'b0;
        tick();
        rvalid = 1'b1; rlast = 1'b1; #1;
        chk("stray_rready", 64'(rready), 64'h1);
        chk("stray_rvalid", 64'(s_rvalid), 64'h0);
        tick(); rvalid = 1'b0; rlast = 1'b0;
        chk("stray_set", 64'(stray_beat), 64'h1);
        tick();
        chk("stray_sticky", 64'(stray_beat), 64'h1);

        // Cores 0 and 3 both request continuously.
        set_req(0, 32'h900, 8'd0); s_arvalid = 4'h9;
        for (int g = 0; g < 3; g++) begin
            #1;
`ifdef L1_ARB_PRIO0_EN
            chk("arb_grant", 64'(s_arready), 64'h1);
`else
            chk("arb_grant", 64'(s_arready), 64'((g % 2 == 0) ? 4'h1 : 4'h8));
`endif
            tick();
        end
        s_arvalid = 4'h8; #1;
        chk("arb_grant_core3", 64'(s_arready), 64'h8);
        tick(); s_arvalid = 4'h0;
        chk("arb_outstanding", 64'(outstanding), 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
